// File: rtl/sudoku_mask_decode.sv
// sudoku_mask_decode
//   Back end of the candidate-mask pipeline. Captures a 729-bit elimination
//   mask and streams it out as decoded cell digits, CELLS_PER_BEAT cells per
//   beat. Frame summary flags are presented together with the last beat.
//
//   Mask bit i: cell c = i/9 (c = x*9+y), value v = i%9; a set bit excludes
//   digit v+1 for that cell.
//   Cell digit: one clear bit at v -> v+1, none clear -> 4'hF, several -> 0.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   mask_valid/ready  input mask handshake (ready while idle)
//   mask_in           729-bit elimination mask, sampled only at accept
//   out_valid/ready   output beat handshake
//   out_cell          index of the first cell in the beat
//   out_digits        cell k of the beat at [4k+3:4k]
//   out_last          final beat of the frame
//   sum_solved        with out_last: every cell decodes to 1..9
//   sum_error         with out_last: at least one cell has all bits set
//   sum_unsolved_cnt  with out_last: number of cells with >=2 clear bits
//   abort             (only with SUDOKU_MASK_DEC_ABORT_EN) drops the frame
//
// Configuration
//   SUDOKU_MASK_DEC_ABORT_EN  adds the abort input; a frame in progress
//                             returns to idle without issuing out_last.

module sudoku_mask_decode #(
  parameter int unsigned CELLS_PER_BEAT = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mask_valid,
  output logic                        mask_ready,
  input  logic [728:0]                mask_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [6:0]                  out_cell,
  output logic [4*CELLS_PER_BEAT-1:0] out_digits,
  output logic                        out_last,
  output logic                        sum_solved,
  output logic                        sum_error,
`ifdef SUDOKU_MASK_DEC_ABORT_EN
  input  logic                        abort,
`endif
  output logic [6:0]                  sum_unsolved_cnt
);

  localparam int unsigned BEATS  = 81 / CELLS_PER_BEAT;
  localparam int unsigned BEAT_W = 9 * CELLS_PER_BEAT;

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                      r_state;
  logic [728:0]                r_mask;
  logic [6:0]                  r_beat;
  logic                        r_err;
  logic [6:0]                  r_ucnt;

  logic [4*CELLS_PER_BEAT-1:0] w_digits;
  logic                        w_beat_err;
  logic [6:0]                  w_beat_ucnt;
  logic                        w_last;
  logic                        w_err_tot;
  logic [6:0]                  w_ucnt_tot;

  function automatic logic [3:0] dec_cell(input logic [8:0] b);
    logic [3:0]  d;
    int unsigned n;
    d = '0;
    n = 0;
    for (int unsigned v = 0; v < 9; v++) begin
      if (!b[v]) begin
        n = n + 1;
        d = 4'(v + 1);
      end
    end
    if (n == 0)      dec_cell = 4'hF;
    else if (n == 1) dec_cell = d;
    else             dec_cell = 4'd0;
  endfunction

  // The mask register shifts down one beat per handshake, so the current
  // beat's cells always sit in the low bits and a finished frame leaves it 0.
  always_comb begin
    w_digits    = '0;
    w_beat_err  = 1'b0;
    w_beat_ucnt = '0;
    for (int unsigned k = 0; k < CELLS_PER_BEAT; k++) begin
      w_digits[4*k +: 4] = dec_cell(r_mask[9*k +: 9]);
      if (w_digits[4*k +: 4] == 4'hF) w_beat_err  = 1'b1;
      if (w_digits[4*k +: 4] == 4'd0) w_beat_ucnt = w_beat_ucnt + 7'd1;
    end
  end

  assign w_last     = (r_state == S_STREAM) && (r_beat == 7'(BEATS - 1));
  assign w_err_tot  = r_err | w_beat_err;
  assign w_ucnt_tot = r_ucnt + w_beat_ucnt;

  assign mask_ready       = (r_state == S_IDLE);
  assign out_valid        = (r_state == S_STREAM);
  assign out_cell         = 7'(r_beat * CELLS_PER_BEAT);
  assign out_digits       = w_digits;
  assign out_last         = w_last;
  assign sum_error        = w_last & w_err_tot;
  assign sum_unsolved_cnt = w_last ? w_ucnt_tot : '0;
  assign sum_solved       = w_last & !w_err_tot & (w_ucnt_tot == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_beat  <= '0;
      r_err   <= 1'b0;
      r_ucnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mask_valid) begin
            r_state <= S_STREAM;
            r_mask  <= mask_in;
            r_beat  <= '0;
            r_err   <= 1'b0;
            r_ucnt  <= '0;
          end
        end
        S_STREAM: begin
`ifdef SUDOKU_MASK_DEC_ABORT_EN
          if (abort) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_beat  <= '0;
            r_err   <= 1'b0;
            r_ucnt  <= '0;
          end else
`endif
          if (out_ready) begin
            r_mask <= r_mask >> BEAT_W;
            if (w_last) begin
              r_state <= S_IDLE;
              r_beat  <= '0;
              r_err   <= 1'b0;
              r_ucnt  <= '0;
            end else begin
              r_beat <= r_beat + 7'd1;
              r_err  <= w_err_tot;
              r_ucnt <= w_ucnt_tot;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
